// File: rtl/lvds_rx_decoder.sv
// rtl/lvds_rx_decoder.sv - 7:1 LVDS receiver word alignment and video decode
module lvds_rx_decoder #(
    parameter logic [6:0] CLK_PATTERN  = 7'b1100011,
    parameter int         LOCK_COUNT   = 16,
    parameter int         UNLOCK_COUNT = 4,
    parameter int         SLIP_WAIT    = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [6:0]  i_clk_lane,
    input  logic [6:0]  i_lane0,
    input  logic [6:0]  i_lane1,
    input  logic [6:0]  i_lane2,
    input  logic [6:0]  i_lane3,
    output logic        o_bitslip,
    output logic        o_locked,
    output logic        o_de,
    output logic        o_hs,
    output logic        o_vs,
    output logic [23:0] o_color,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_frame_start,
    output logic [11:0] o_line_len
);
    localparam logic [1:0] ST_SEARCH    = 2'd0;
    localparam logic [1:0] ST_WAIT_SLIP = 2'd1;
    localparam logic [1:0] ST_CHECK     = 2'd2;
    localparam logic [1:0] ST_LOCKED    = 2'd3;

    localparam logic [15:0] LOCK_N   = 16'(LOCK_COUNT);
    localparam logic [15:0] UNLOCK_N = 16'(UNLOCK_COUNT);
    localparam logic [15:0] SLIP_N   = 16'(SLIP_WAIT);
    localparam logic [11:0] SAT      = 12'hFFF;

    logic [1:0]  state, state_next;
    // One counter serves the slip wait, the match run and the miss run.
    logic [15:0] cnt, cnt_next, cnt_inc;
    logic        slip_next, locked_next, match;
    logic        de_in, hs_in, vs_in, de_rise, de_fall, vs_rise, vs_seen;
    logic [23:0] color_in;
    logic        unused_lane3_bit;

    assign match            = (i_clk_lane == CLK_PATTERN);
    assign cnt_inc          = cnt + 16'd1;
    assign locked_next      = (state_next == ST_LOCKED);
    assign unused_lane3_bit = i_lane3[6];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        slip_next  = 1'b0;
        case (state)
            ST_SEARCH: begin
                cnt_next = 16'd0;
                if (match) begin
                    if (LOCK_N <= 16'd1) begin
                        state_next = ST_LOCKED;
                    end else begin
                        state_next = ST_CHECK;
                        cnt_next   = 16'd1;
                    end
                end else begin
                    slip_next  = 1'b1;
                    state_next = (SLIP_N == 16'd0) ? ST_SEARCH : ST_WAIT_SLIP;
                end
            end
            ST_WAIT_SLIP: begin
                if (cnt_inc >= SLIP_N) begin
                    state_next = ST_SEARCH;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_CHECK: begin
                if (!match) begin
                    state_next = ST_SEARCH;
                    cnt_next   = 16'd0;
                end else if (cnt_inc >= LOCK_N) begin
                    state_next = ST_LOCKED;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                if (match) begin
                    cnt_next = 16'd0;
                end else if (cnt_inc >= UNLOCK_N) begin
                    state_next = ST_SEARCH;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
        endcase
    end

    assign de_in    = i_lane2[6];
    assign vs_in    = i_lane2[5];
    assign hs_in    = i_lane2[4];
    assign color_in = {i_lane3[1:0], i_lane0[5:0],
                       i_lane3[3:2], i_lane1[4:0], i_lane0[6],
                       i_lane3[5:4], i_lane2[3:0], i_lane1[6:5]};
    // Edges are taken against the registered (lock-gated) outputs.
    assign de_rise  = de_in & ~o_de;
    assign de_fall  = ~de_in & o_de;
    assign vs_rise  = vs_in & ~o_vs;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_SEARCH;
            cnt           <= 16'd0;
            o_bitslip     <= 1'b0;
            o_locked      <= 1'b0;
            o_de          <= 1'b0;
            o_hs          <= 1'b0;
            o_vs          <= 1'b0;
            o_color       <= 24'd0;
            o_x           <= 12'd0;
            o_y           <= 12'd0;
            o_frame_start <= 1'b0;
            o_line_len    <= 12'd0;
            vs_seen       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            o_bitslip <= slip_next;
            o_locked  <= locked_next;
            if (!locked_next) begin
                o_de          <= 1'b0;
                o_hs          <= 1'b0;
                o_vs          <= 1'b0;
                o_color       <= 24'd0;
                o_x           <= 12'd0;
                o_y           <= 12'd0;
                o_frame_start <= 1'b0;
                vs_seen       <= 1'b0;
            end else begin
                o_de          <= de_in;
                o_hs          <= hs_in;
                o_vs          <= vs_in;
                o_color       <= color_in;
                o_frame_start <= de_rise & (vs_seen | vs_rise);
                if (de_rise) begin
                    vs_seen <= 1'b0;
                end else if (vs_rise) begin
                    vs_seen <= 1'b1;
                end
                if (de_rise) begin
                    o_x <= 12'd0;
                end else if (de_in && o_x != SAT) begin
                    o_x <= o_x + 12'd1;
                end
                if (vs_rise) begin
                    o_y <= 12'd0;
                end else if (de_fall && o_y != SAT) begin
                    o_y <= o_y + 12'd1;
                end
                if (de_fall) begin
                    o_line_len <= (o_x == SAT) ? SAT : o_x + 12'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lvds_rx_decoder.sv
// tb/tb_lvds_rx_decoder.sv - self-checking bench for lvds_rx_decoder
module tb_lvds_rx_decoder;
    localparam logic [6:0] PAT      = 7'b1100011;
    localparam int         LOCK_N   = 16;
    localparam int         UNLOCK_N = 4;
    localparam int         SLIP_N   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  clk_lane = PAT;
    logic [6:0]  l0 = '0, l1 = '0, l2 = '0, l3 = '0;
    logic        o_bitslip, o_locked, o_de, o_hs, o_vs, o_frame_start;
    logic [23:0] o_color;
    logic [11:0] o_x, o_y, o_line_len;

    int vectors = 0;
    int errors  = 0;
    int rot     = 0;
    bit bad     = 1'b0;

    always #5 clk = ~clk;

    lvds_rx_decoder #(
        .CLK_PATTERN(PAT), .LOCK_COUNT(LOCK_N), .UNLOCK_COUNT(UNLOCK_N), .SLIP_WAIT(SLIP_N)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_lane(clk_lane),
        .i_lane0(l0), .i_lane1(l1), .i_lane2(l2), .i_lane3(l3),
        .o_bitslip(o_bitslip), .o_locked(o_locked), .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs),
        .o_color(o_color), .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start),
        .o_line_len(o_line_len)
    );

    // Clock-lane word seen by a deserializer whose boundary is off by n bits.
    function automatic logic [6:0] rotw(input int n);
        logic [13:0] d;
        d = {PAT, PAT};
        return d[13-n -: 7];
    endfunction

    function automatic int sat(input int v);
        return (v > 4095) ? 4095 : v;
    endfunction

    task automatic put(input logic [23:0] c, input logic hs, input logic vs, input logic de);
        l0 = {c[8], c[21:16]};
        l1 = {c[1], c[0], c[13:9]};
        l2 = {de, vs, hs, c[5:2]};
        l3 = {1'($urandom_range(1)), c[7:6], c[15:14], c[23:22]};
    endtask

    // One word period; a bitslip request moves the modelled boundary one bit closer.
    task automatic cyc();
        clk_lane = bad ? (rotw(rot) ^ 7'(1 << $urandom_range(6))) : rotw(rot);
        @(posedge clk);
        #1;
        if (o_bitslip) rot = (rot + 6) % 7;
    endtask

    task automatic test_reset();
        rst = 1'b1; rot = 3; bad = 1'b0;
        put(24'hFF0000, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc();
        vectors++; if ({o_bitslip, o_locked, o_de, o_hs, o_vs, o_frame_start} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {o_bitslip, o_locked, o_de, o_hs, o_vs, o_frame_start}); end
        vectors++; if (o_color !== 24'h0) begin errors++; $display("FAIL reset_color: got %h want 000000", o_color); end
        vectors++; if (o_x !== 12'd0 || o_y !== 12'd0) begin errors++; $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", o_x, o_y); end
        vectors++; if (o_line_len !== 12'd0) begin errors++; $display("FAIL reset_line_len: got %0d want 0", o_line_len); end
    endtask

    task automatic test_align();
        int slips[$];
        int first_lock;
        int exp_lock;
        first_lock = -1;
        rst = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            cyc();
            if (o_bitslip) slips.push_back(k);
            if (o_locked === 1'b1) begin
                first_lock = k;
                break;
            end
            vectors++; if (o_de !== 1'b0 || o_color !== 24'h0) begin errors++; $display("FAIL align_gate k%0d: got de=%b color=%h want 0 0", k, o_de, o_color); end
        end
        vectors++; if (slips.size() != 3) begin errors++; $display("FAIL align_slip_count: got %0d want 3", slips.size()); end
        for (int i = 0; i < 3 && i < slips.size(); i++) begin
            vectors++; if (slips[i] != 1 + i * (SLIP_N + 1)) begin errors++; $display("FAIL align_slip_time %0d: got %0d want %0d", i, slips[i], 1 + i * (SLIP_N + 1)); end
        end
        exp_lock = 1 + 3 * (SLIP_N + 1) + LOCK_N - 1;
        vectors++; if (first_lock != exp_lock) begin errors++; $display("FAIL align_lock_time: got %0d want %0d", first_lock, exp_lock); end
        vectors++; if (o_de !== 1'b1 || o_color !== 24'hFF0000 || o_frame_start !== 1'b0) begin errors++; $display("FAIL align_first_out: got de=%b color=%h fs=%b want 1 ff0000 0", o_de, o_color, o_frame_start); end
    endtask

    task automatic test_color();
        logic [23:0] c, c_prev;
        logic        hs, hs_prev;
        put(24'hFF0000, 1'b0, 1'b0, 1'b1); cyc();
        vectors++; if (o_de !== 1'b1 || o_color !== 24'hFF0000) begin errors++; $display("FAIL color_red: got de=%b color=%h want 1 ff0000", o_de, o_color); end
        put(24'h000000, 1'b0, 1'b0, 1'b1); cyc();
        vectors++; if (o_de !== 1'b1 || o_color !== 24'h000000) begin errors++; $display("FAIL color_zero: got de=%b color=%h want 1 000000", o_de, o_color); end
        c = $urandom; hs = 1'($urandom_range(1));
        for (int i = 0; i < 32; i++) begin
            put(c, hs, 1'b0, 1'b1);
            cyc();
            c_prev = c; hs_prev = hs;
            c = $urandom; hs = 1'($urandom_range(1));
            put(c, hs, 1'b0, 1'b1);
            #1;
            vectors++; if (o_color !== c_prev || o_hs !== hs_prev || o_de !== 1'b1 || o_vs !== 1'b0 || o_frame_start !== 1'b0) begin errors++; $display("FAIL color_rand %0d: got color=%h hs=%b de=%b vs=%b fs=%b want %h %b 1 0 0", i, o_color, o_hs, o_de, o_vs, o_frame_start, c_prev, hs_prev); end
        end
    endtask

    task automatic test_frame();
        localparam int W  = 960;
        localparam int NL = 12;
        logic [23:0] c;
        int fs_count, nb;
        fs_count = 0;
        repeat (3) begin put($urandom, 1'b0, 1'b0, 1'b0); cyc(); end
        put(24'h0, 1'b0, 1'b1, 1'b0); cyc();
        vectors++; if (o_vs !== 1'b1 || o_y !== 12'd0) begin errors++; $display("FAIL frame_vs: got vs=%b y=%0d want 1 0", o_vs, o_y); end
        put(24'h0, 1'b0, 1'b1, 1'b0); cyc();
        repeat (2) begin put(24'h0, 1'b0, 1'b0, 1'b0); cyc(); end
        for (int ln = 0; ln < NL; ln++) begin
            for (int p = 0; p < W; p++) begin
                c = $urandom;
                put(c, 1'b0, 1'b0, 1'b1); cyc();
                if (o_frame_start) fs_count++;
                vectors++; if (o_de !== 1'b1 || o_color !== c || o_x !== 12'(p) || o_y !== 12'(ln) || o_frame_start !== (ln == 0 && p == 0)) begin errors++; $display("FAIL frame_px l%0d p%0d: got de=%b color=%h x=%0d y=%0d fs=%b want 1 %h %0d %0d %b", ln, p, o_de, o_color, o_x, o_y, o_frame_start, c, p, ln, (ln == 0 && p == 0)); end
            end
            nb = $urandom_range(2, 5);
            for (int b = 0; b < nb; b++) begin
                put($urandom, (b == 1), 1'b0, 1'b0); cyc();
                if (o_frame_start) fs_count++;
                vectors++; if (o_de !== 1'b0 || o_hs !== (b == 1) || o_x !== 12'(W - 1) || o_y !== 12'(ln + 1) || o_line_len !== 12'(W)) begin errors++; $display("FAIL frame_blank l%0d b%0d: got de=%b hs=%b x=%0d y=%0d len=%0d want 0 %b %0d %0d %0d", ln, b, o_de, o_hs, o_x, o_y, o_line_len, (b == 1), W - 1, ln + 1, W); end
            end
        end
        vectors++; if (fs_count != 1) begin errors++; $display("FAIL frame_start_count: got %0d want 1", fs_count); end
    endtask

    task automatic test_sat();
        put(24'h0, 1'b0, 1'b1, 1'b0); cyc();
        put(24'h0, 1'b0, 1'b0, 1'b0); cyc();
        for (int p = 0; p < 4100; p++) begin
            put($urandom, 1'b0, 1'b0, 1'b1); cyc();
            vectors++; if (o_x !== 12'(sat(p))) begin errors++; $display("FAIL sat_x p%0d: got %0d want %0d", p, o_x, sat(p)); end
        end
        put(24'h0, 1'b0, 1'b0, 1'b0); cyc();
        vectors++; if (o_line_len !== 12'd4095 || o_y !== 12'd1) begin errors++; $display("FAIL sat_line_len: got len=%0d y=%0d want 4095 1", o_line_len, o_y); end
        for (int ln = 1; ln < 4100; ln++) begin
            put($urandom, 1'b0, 1'b0, 1'b1); cyc();
            vectors++; if (o_y !== 12'(sat(ln)) || o_x !== 12'd0) begin errors++; $display("FAIL sat_y l%0d: got y=%0d x=%0d want %0d 0", ln, o_y, o_x, sat(ln)); end
            put(24'h0, 1'b0, 1'b0, 1'b0); cyc();
        end
        vectors++; if (o_y !== 12'd4095 || o_line_len !== 12'd1) begin errors++; $display("FAIL sat_y_end: got y=%0d len=%0d want 4095 1", o_y, o_line_len); end
        // VS rising in the same word that ends DE: clearing y takes priority
        put(24'h0, 1'b0, 1'b0, 1'b1); cyc();
        put(24'h0, 1'b0, 1'b1, 1'b0); cyc();
        vectors++; if (o_y !== 12'd0 || o_vs !== 1'b1) begin errors++; $display("FAIL vs_de_fall: got y=%0d vs=%b want 0 1", o_y, o_vs); end
        put(24'h0, 1'b0, 1'b0, 1'b0); cyc();
        put($urandom, 1'b0, 1'b0, 1'b1); cyc();
        vectors++; if (o_frame_start !== 1'b1 || o_x !== 12'd0) begin errors++; $display("FAIL vs_de_fs: got fs=%b x=%0d want 1 0", o_frame_start, o_x); end
    endtask

    task automatic test_unlock();
        logic [23:0] c;
        int lock_k;
        put(24'h0, 1'b0, 1'b0, 1'b0); cyc();
        for (int p = 0; p < 7; p++) begin
            bad = (p >= 3 && p < 6);
            put($urandom, 1'b0, 1'b0, 1'b1); cyc();
            vectors++; if (o_locked !== 1'b1 || o_de !== 1'b1 || o_x !== 12'(p)) begin errors++; $display("FAIL unlock_3bad p%0d: got locked=%b de=%b x=%0d want 1 1 %0d", p, o_locked, o_de, o_x, p); end
        end
        bad = 1'b0;
        repeat (2) begin put(24'h0, 1'b0, 1'b0, 1'b0); cyc(); end
        vectors++; if (o_line_len !== 12'd7) begin errors++; $display("FAIL unlock_len: got %0d want 7", o_line_len); end
        for (int p = 0; p < 2; p++) begin put($urandom, 1'b0, 1'b0, 1'b1); cyc(); end
        put($urandom, 1'b0, 1'b1, 1'b1); cyc();
        vectors++; if (o_y !== 12'd0 || o_x !== 12'd2) begin errors++; $display("FAIL unlock_vs_mid: got y=%0d x=%0d want 0 2", o_y, o_x); end
        bad = 1'b1;
        for (int i = 0; i < UNLOCK_N; i++) begin
            c = $urandom;
            put(c, 1'b1, 1'b1, 1'b1); cyc();
            if (i < UNLOCK_N - 1) begin
                vectors++; if (o_locked !== 1'b1 || o_x !== 12'(3 + i)) begin errors++; $display("FAIL unlock_hold %0d: got locked=%b x=%0d want 1 %0d", i, o_locked, o_x, 3 + i); end
            end else begin
                vectors++; if ({o_locked, o_de, o_hs, o_vs, o_frame_start} !== 5'b0 || o_color !== 24'h0) begin errors++; $display("FAIL unlock_drop: got flags=%b color=%h want 00000 000000", {o_locked, o_de, o_hs, o_vs, o_frame_start}, o_color); end
                vectors++; if (o_x !== 12'd0 || o_y !== 12'd0 || o_line_len !== 12'd7) begin errors++; $display("FAIL unlock_counters: got x=%0d y=%0d len=%0d want 0 0 7", o_x, o_y, o_line_len); end
            end
        end
        bad = 1'b0; rot = 2;
        put($urandom, 1'b0, 1'b0, 1'b1);
        cyc();
        vectors++; if (o_bitslip !== 1'b1) begin errors++; $display("FAIL unlock_reslip: got %b want 1", o_bitslip); end
        lock_k = -1;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (o_locked === 1'b1) begin lock_k = k; break; end
        end
        vectors++; if (lock_k < 0) begin errors++; $display("FAIL unlock_relock: got no lock want lock within 100 cycles"); end
        vectors++; if (o_frame_start !== 1'b0 || o_de !== 1'b1 || o_x !== 12'd0) begin errors++; $display("FAIL unlock_vs_seen: got fs=%b de=%b x=%0d want 0 1 0", o_frame_start, o_de, o_x); end
    endtask

    task automatic test_reset_midline();
        put($urandom, 1'b0, 1'b0, 1'b1);
        cyc(); cyc();
        vectors++; if (o_locked !== 1'b1 || o_x !== 12'd2) begin errors++; $display("FAIL rst_pre: got locked=%b x=%0d want 1 2", o_locked, o_x); end
        rst = 1'b1;
        #1;
        vectors++; if ({o_bitslip, o_locked, o_de, o_hs, o_vs, o_frame_start} !== 6'b0 || o_color !== 24'h0) begin errors++; $display("FAIL rst_async_flags: got %b color=%h want 000000 000000", {o_bitslip, o_locked, o_de, o_hs, o_vs, o_frame_start}, o_color); end
        vectors++; if (o_x !== 12'd0 || o_y !== 12'd0 || o_line_len !== 12'd0) begin errors++; $display("FAIL rst_async_cnt: got x=%0d y=%0d len=%0d want 0 0 0", o_x, o_y, o_line_len); end
        cyc(); cyc();
        rst = 1'b0; rot = 0; bad = 1'b0;
        for (int k = 1; k < LOCK_N; k++) begin
            cyc();
            vectors++; if (o_locked !== 1'b0 || o_bitslip !== 1'b0) begin errors++; $display("FAIL rst_relock_early k%0d: got locked=%b slip=%b want 0 0", k, o_locked, o_bitslip); end
        end
        cyc();
        vectors++; if (o_locked !== 1'b1) begin errors++; $display("FAIL rst_relock: got %b want 1", o_locked); end
    endtask

    initial begin
        test_reset();
        test_align();
        test_color();
        test_frame();
        test_sat();
        test_unlock();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
